// File: rtl/mem_sched_pkg.sv
// Shared types for the data-memory scheduler: LSQ/CDB packets, store buffer entry, mode enum.
package mem_sched_pkg;

  localparam int unsigned ROB_W = 5;

  typedef struct packed {
    logic [31:0]      address;
    logic [ROB_W-1:0] ROB_entry;
  } lsq_packet_t;

  typedef struct packed {
    logic [ROB_W-1:0] dest_ROB_entry;
    logic [31:0]      result;
    logic             branch_result;
    logic             from_memory;
  } CDB_packet_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  typedef enum logic {
    LOAD_PRI,
    STORE_PRI
  } mem_sched_mode_t;

endpackage

// File: rtl/mem_sched_store_buf.sv
// Committed-store FIFO with a wrap-bit pointer pair and a parallel word-address match.
module mem_sched_store_buf
  import mem_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  sb_entry_t              push_entry,
  input  logic                   pop,
  output sb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  input  logic [29:0]            match_word,
  output logic                   match
);

  localparam int unsigned PW = $clog2(DEPTH);

  sb_entry_t   entries [DEPTH];
  logic [PW:0] rd_ptr;
  logic [PW:0] wr_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[PW-1:0] == wr_ptr[PW-1:0]) && (rd_ptr[PW] != wr_ptr[PW]);
  assign head  = entries[rd_ptr[PW-1:0]];

  // Pointer update; a push while full or a pop while empty is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; unreset because only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) entries[wr_ptr[PW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (({1'b0, PW'(i) - rd_ptr[PW-1:0]} < count) &&
          (entries[PW'(i)].addr[31:2] == match_word)) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_sched.sv
// Single-port data memory scheduler: store buffer, watermark arbitration, one-entry CDB slot.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned HI_WM    = 3,
  parameter int unsigned LO_WM    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      st_commit_valid,
  input  logic [31:0]               st_commit_addr,
  input  logic [31:0]               st_commit_data,
  output logic                      st_commit_ready,
  input  logic                      ld_req_valid,
  input  lsq_packet_t               ld_req,
  output logic                      ld_req_ready,
  input  logic                      drain_req,
  input  logic                      flush,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [31:0]               mem_rdata,
  output CDB_packet_t               cdb_out,
  output logic                      cdb_valid,
  input  logic                      cdb_yummy,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty
);

  localparam int unsigned CW = $clog2(SB_DEPTH) + 1;

  mem_sched_mode_t mode_q, mode_d;
  sb_entry_t       head;
  logic            sb_full, sb_match, st_alias, ld_elig, push, do_load, do_store;
  logic [CW-1:0]   count_next;
  logic [31:0]     result_q;
  logic [ROB_W-1:0] rob_q;

  assign push            = st_commit_valid && !sb_full;
  assign st_commit_ready = !sb_full;

  mem_sched_store_buf #(
    .DEPTH(SB_DEPTH)
  ) u_store_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{addr: st_commit_addr, data: st_commit_data}),
    .pop        (do_store),
    .head       (head),
    .count      (sb_count),
    .full       (sb_full),
    .empty      (sb_empty),
    .match_word (ld_req.address[31:2]),
    .match      (sb_match)
  );

  // A load may not pass an older store to the same word, including one committing right now.
  assign st_alias = st_commit_valid && (st_commit_addr[31:2] == ld_req.address[31:2]);
  assign ld_elig  = ld_req_valid && !flush && (!cdb_valid || cdb_yummy) && !sb_match && !st_alias;

  // Arbitration and mode next-state.
  always_comb begin
    do_load    = 1'b0;
    do_store   = 1'b0;
    mode_d     = mode_q;
    count_next = '0;
    case (mode_q)
      STORE_PRI: begin
        if (!sb_empty)    do_store = 1'b1;
        else if (ld_elig) do_load  = 1'b1;
      end
      default: begin
        if (ld_elig)        do_load  = 1'b1;
        else if (!sb_empty) do_store = 1'b1;
      end
    endcase
    count_next = sb_count + CW'(push) - CW'(do_store);
    case (mode_q)
      STORE_PRI: if (32'(count_next) <= LO_WM && !drain_req) mode_d = LOAD_PRI;
      default:   if (32'(count_next) >= HI_WM || drain_req)  mode_d = STORE_PRI;
    endcase
  end

  // Memory port drive; address and write data are zero when not in use.
  always_comb begin
    mem_we       = do_store;
    mem_re       = do_load;
    ld_req_ready = do_load;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (do_store) begin
      mem_addr  = head.addr;
      mem_wdata = head.data;
    end else if (do_load) begin
      mem_addr = ld_req.address;
    end
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (reset) mode_q <= LOAD_PRI;
    else       mode_q <= mode_d;
  end

  // CDB slot: a new load overwrites in the cycle the old result is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      result_q  <= '0;
      rob_q     <= '0;
    end else if (do_load) begin
      cdb_valid <= 1'b1;
      result_q  <= mem_rdata;
      rob_q     <= ld_req.ROB_entry;
    end else if (flush || cdb_yummy) begin
      cdb_valid <= 1'b0;
    end
  end

  // CDB packet assembly.
  always_comb begin
    cdb_out                = '0;
    cdb_out.dest_ROB_entry = rob_q;
    cdb_out.result         = result_q;
    cdb_out.branch_result  = 1'b0;
    cdb_out.from_memory    = cdb_valid;
  end

endmodule
